// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the wide add/subtract sequencer: controller state
// encoding and the default slice geometry.
package wide_add_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WORD_W    = 16;
  localparam int DEFAULT_NUM_WORDS = 4;

endpackage

// File: rtl/wide_add_sequencer_cla_slice.sv
// Combinational WORD_W-bit carry-lookahead adder built from 4-bit P/G groups
// with a second lookahead level across the groups.
module cla_slice #(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  localparam int NG = WORD_W / 4;

  logic [WORD_W-1:0] p;
  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] c;
  logic [NG-1:0]     gp;
  logic [NG-1:0]     gg;
  logic [NG:0]       gc;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    gp = '0;
    gg = '0;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
  end

  // Each group carry is a flat sum of products over all lower groups and cin.
  always_comb begin : group_carry
    logic term;
    logic prop;
    gc    = '0;
    term  = 1'b0;
    prop  = 1'b0;
    gc[0] = cin;
    for (int j = 0; j < NG; j++) begin
      term = gg[j];
      prop = gp[j];
      for (int k = j - 1; k >= 0; k--) begin
        term = term | (prop & gg[k]);
        prop = prop & gp[k];
      end
      gc[j+1] = term | (prop & cin);
    end
  end

  always_comb begin
    c = '0;
    for (int j = 0; j < NG; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[NG];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder/subtractor: one shared CLA slice walks the operand
// words LSB-first, chaining its carry through a register between cycles.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int WORD_W    = DEFAULT_WORD_W,
  parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
  localparam int OP_W     = WORD_W * NUM_WORDS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_a,
  input  logic [OP_W-1:0] in_b,
  input  logic            in_cin,
  input  logic            in_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_sum,
  output logic            out_cout,
  output logic            out_ovf
);

  localparam int              IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  idx;
  logic [OP_W-1:0]   a_reg;
  logic [OP_W-1:0]   b_reg;
  logic              carry;
  logic [OP_W-1:0]   sum_reg;
  logic              cout_reg;
  logic              ovf_reg;
  logic [WORD_W-1:0] slice_a;
  logic [WORD_W-1:0] slice_b;
  logic [WORD_W-1:0] slice_sum;
  logic              slice_cout;

  assign slice_a = a_reg[int'(idx)*WORD_W +: WORD_W];
  assign slice_b = b_reg[int'(idx)*WORD_W +: WORD_W];

  cla_slice #(
    .WORD_W (WORD_W)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (idx == LAST_IDX) next_state = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Subtraction is folded in at accept time: B is inverted and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            b_reg    <= in_sub ? ~in_b : in_b;
            carry    <= in_sub | in_cin;
            idx      <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
          end
        end
        ST_RUN: begin
          sum_reg[int'(idx)*WORD_W +: WORD_W] <= slice_sum;
          carry <= slice_cout;
          if (idx == LAST_IDX) begin
            idx      <= '0;
            cout_reg <= slice_cout;
            ovf_reg  <= (slice_a[WORD_W-1] == slice_b[WORD_W-1])
                      & (slice_sum[WORD_W-1] != slice_a[WORD_W-1]);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = cout_reg;
  assign out_ovf  = ovf_reg;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer: directed corner cases, backpressure,
// mid-operation reset and a long randomized run against a 64-bit reference model.
module tb_wide_add_sequencer;

  localparam int OP_W = 64;

  typedef struct {
    logic [OP_W-1:0] sum;
    logic            cout;
    logic            ovf;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [OP_W-1:0] in_a = '0;
  logic [OP_W-1:0] in_b = '0;
  logic            in_cin = 1'b0;
  logic            in_sub = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [OP_W-1:0] out_sum;
  logic            out_cout;
  logic            out_ovf;

  int   n_checks = 0;
  int   n_fail = 0;
  bit   rand_ready = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  wide_add_sequencer #(
    .WORD_W    (16),
    .NUM_WORDS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  task automatic check_output(input string name, input logic [OP_W-1:0] act,
                              input logic [OP_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Arithmetic-level reference: unsigned result/borrow plus true signed range test.
  function automatic exp_t ref_model(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                     input logic cin, input logic sub);
    exp_t               r;
    logic [OP_W:0]      w;
    logic signed [65:0] s;
    if (sub) begin
      r.sum  = a - b;
      r.cout = (a >= b);
      s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
    end else begin
      w = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      r.sum  = w[OP_W-1:0];
      r.cout = w[OP_W];
      s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'd0, cin});
    end
    r.ovf = !((s[65:63] == 3'b000) || (s[65:63] == 3'b111));
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic [OP_W-1:0] sum, input logic cout,
                                  input logic ovf);
    exp_t r;
    r.sum  = sum;
    r.cout = cout;
    r.ovf  = ovf;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) check_output("in_ready_low_in_done", {63'd0, in_ready}, 64'd0);
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_output: got result %h, required no pending result",
                 out_sum);
      end else begin
        mon_e = sb.pop_front();
        check_output("sum", out_sum, mon_e.sum);
        check_output("cout", {63'd0, out_cout}, {63'd0, mon_e.cout});
        check_output("ovf", {63'd0, out_ovf}, {63'd0, mon_e.ovf});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Presents operands from a negedge and returns #1 after the accepting edge.
  task automatic apply_stimulus(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                input logic cin, input logic sub, input exp_t e,
                                input bit hold_valid);
    int waited = 0;
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got in_ready=0, required 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check_output("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_out_valid();
    int waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_output("out_valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    check_output({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check_output({tag, "_out_sum"}, out_sum, 64'd0);
    check_output({tag, "_out_cout"}, {63'd0, out_cout}, 64'd0);
    check_output({tag, "_out_ovf"}, {63'd0, out_ovf}, 64'd0);
  endtask

  initial begin
    exp_t            bp;
    logic [OP_W-1:0] ra;
    logic [OP_W-1:0] rb;
    logic            rcin;
    logic            rsub;

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Carry ripples out of the first slice; output must appear exactly 4 cycles later.
    apply_stimulus(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
                   mk_exp(64'h0000_0000_0001_0000, 1'b0, 1'b0), 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("latency_cycle%0d", k), {63'd0, out_valid}, {63'd0, (k == 4)});
    end
    wait_drain();

    apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
                   mk_exp(64'h0, 1'b1, 1'b0), 1'b0);
    apply_stimulus(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
                   mk_exp(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1), 1'b0);
    apply_stimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                   mk_exp(64'h8000_0000_0000_0000, 1'b0, 1'b1), 1'b0);
    apply_stimulus(64'h1, 64'h2, 1'b1, 1'b1,
                   mk_exp(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0), 1'b0);
    wait_drain();

    // Backpressure: results must hold while new operands are offered and ignored.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    bp = ref_model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
    apply_stimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1, bp, 1'b0);
    wait_out_valid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      check_output("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check_output("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check_output("bp_out_sum", out_sum, bp.sum);
      check_output("bp_out_cout", {63'd0, out_cout}, {63'd0, bp.cout});
      check_output("bp_out_ovf", {63'd0, out_ovf}, {63'd0, bp.ovf});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    check_output("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    wait_drain();

    // Abort an operation in its second RUN cycle; nothing may leak into the next one.
    apply_stimulus(64'hDEAD_BEEF_CAFE_F00D, 64'h1111_2222_3333_4444, 1'b1, 1'b0,
                   mk_exp(64'h0, 1'b0, 1'b0), 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_values("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(64'h5, 64'h3, 1'b0, 1'b0, mk_exp(64'h8, 1'b0, 1'b0), 1'b0);
    wait_drain();

    // Long random run with in_valid held high and a stalling consumer.
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
        1: rb = 64'h8000_0000_0000_0000;
        2: rb = ra;
        3: ra = 64'h7FFF_FFFF_FFFF_FFFF;
        default: begin
        end
      endcase
      rcin = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      apply_stimulus(ra, rb, rcin, rsub, ref_model(ra, rb, rcin, rsub), 1'b1);
    end
    in_valid = 1'b0;
    wait_drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
